spi_master_command8_address16_data32: RTL and testbench

SPI_MASTER_COMMAND8_ADDRESS16_DATA32 -- requirements
Module: spi_master_command8_address16_data32

---
 rtl/spi_master_command8_address16_data32.sv | 139 +++++++++++++
 tb/tb_spi_master_command8_address16_data32.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_command8_address16_data32.sv
// SPI mode-0 master sending a 56-bit frame: command8, address16, data32, MSB first.
// Define SPI_MASTER_BYTE_SWAP_EN to byte-reverse the data word on transmit and capture.
module spi_master_command8_address16_data32 #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  command8,
    input  logic [15:0] address16,
    input  logic [31:0] data32,
    output logic        busy,
    output logic        done,
    output logic [31:0] read_data32,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SSEL
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

    localparam logic [7:0] HalfLast = 8'(HALF_PERIOD - 1);
    localparam logic [5:0] BitLast  = 6'd55;

    state_e      state_q, state_d;
    logic [7:0]  half_q, half_d;
    logic [5:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic [55:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] tx_word;
    logic [31:0] rx_word;
    logic        half_end;

`ifdef SPI_MASTER_BYTE_SWAP_EN
    assign tx_word = {data32[7:0], data32[15:8], data32[23:16], data32[31:24]};
    assign rx_word = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
`else
    assign tx_word = data32;
    assign rx_word = rx_q;
`endif

    assign half_end = (half_q == HalfLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            half_q  <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    tx_d    = {command8, address16, tx_word};
                    half_d  = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    rx_d    = '0;
                end
            end
            StSetup: begin
                if (half_end) begin
                    state_d = StShift;
                    half_d  = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[30:0], MISO};
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            StShift: begin
                if (!half_end) begin
                    half_d = half_q + 8'd1;
                end else if (sck_q) begin
                    // Falling edge: present the next bit, but hold the last one.
                    half_d = '0;
                    sck_d  = 1'b0;
                    if (bit_q != BitLast) begin
                        tx_d = {tx_q[54:0], 1'b0};
                    end
                end else if (bit_q == BitLast) begin
                    state_d = StGap;
                    half_d  = '0;
                end else begin
                    half_d = '0;
                    bit_d  = bit_q + 6'd1;
                    sck_d  = 1'b1;
                    rx_d   = {rx_q[30:0], MISO};
                end
            end
            StGap: begin
                if (half_end) begin
                    state_d = StIdle;
                    half_d  = '0;
                    bit_d   = '0;
                    tx_d    = '0;
                    rdata_d = rx_word;
                    done    = 1'b1;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign SSEL        = !((state_q == StSetup) || (state_q == StShift));
    assign SCK         = sck_q;
    assign MOSI        = ((state_q == StSetup) || (state_q == StShift)) && tx_q[55];
    assign read_data32 = rdata_q;

endmodule

// File: tb/tb_spi_master_command8_address16_data32.sv
// Directed bench for the 56-bit SPI master: one instance at HALF_PERIOD=2, one at 1.
module tb_spi_master_command8_address16_data32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  command8 = '0;
    logic [15:0] address16 = '0;
    logic [31:0] data32 = '0;
    logic        busy, done, SCK, MOSI, SSEL, MISO;
    logic [31:0] read_data32;
    logic        miso_loop = 1'b1;
    logic        miso_val = 1'b0;
    assign MISO = miso_loop ? MOSI : miso_val;

    spi_master_command8_address16_data32 #(.HALF_PERIOD(2)) dut (
        .clock(clock), .reset(reset), .start(start), .command8(command8),
        .address16(address16), .data32(data32), .busy(busy), .done(done),
        .read_data32(read_data32), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
    );

    logic        start1 = 1'b0;
    logic        busy1, done1, sck1, mosi1, ssel1;
    logic [31:0] rd1;

    spi_master_command8_address16_data32 #(.HALF_PERIOD(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .command8(8'h5A),
        .address16(16'hA55A), .data32(32'h1234_5678), .busy(busy1), .done(done1),
        .read_data32(rd1), .SCK(sck1), .MOSI(mosi1), .MISO(mosi1), .SSEL(ssel1)
    );

`ifdef SPI_MASTER_BYTE_SWAP_EN
    localparam logic [55:0] StreamDead = 56'h010003_EFBEADDE;
    localparam logic [55:0] StreamOne  = 56'hFFFFFF_01000000;
    localparam logic [55:0] StreamCafe = 56'h020010_0DF0FECA;
`else
    localparam logic [55:0] StreamDead = 56'h010003_DEADBEEF;
    localparam logic [55:0] StreamOne  = 56'hFFFFFF_00000001;
    localparam logic [55:0] StreamCafe = 56'h020010_CAFEF00D;
`endif

    int total = 0;
    int bad = 0;

    // Monitor for the HALF_PERIOD=2 instance, sampled mid-cycle.
    logic        sck_prev = 1'b0, busy_prev = 1'b0, ssel_prev = 1'b1;
    int          sck_rises = 0, done_cnt = 0;
    int          busy_run = 0, last_busy_run = 0, ssel_run = 0, last_ssel_run = 0;
    logic [55:0] stream = '0;

    always @(negedge clock) begin
        sck_prev  <= SCK;
        busy_prev <= busy;
        ssel_prev <= SSEL;
        if (SCK && !sck_prev) begin
            sck_rises <= sck_rises + 1;
            stream    <= {stream[54:0], MOSI};
        end
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_run <= busy_run + 1;
        else begin
            busy_run <= 0;
            if (busy_prev) last_busy_run <= busy_run;
        end
        if (!SSEL) ssel_run <= ssel_run + 1;
        else begin
            ssel_run <= 0;
            if (!ssel_prev) last_ssel_run <= ssel_run;
        end
    end

    // Monitor for the HALF_PERIOD=1 instance.
    logic busy1_prev = 1'b0;
    int   run1 = 0, nruns1 = 0, idle1 = 0, gap1 = 0, done1_cnt = 0;
    int   runs1 [2] = '{0, 0};

    always @(negedge clock) begin
        busy1_prev <= busy1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if (busy1 && ssel1) gap1 <= gap1 + 1;
        if (busy1) run1 <= run1 + 1;
        else begin
            run1 <= 0;
            if (busy1_prev) begin
                if (nruns1 < 2) runs1[nruns1] <= run1;
                nruns1 <= nruns1 + 1;
            end
            if (nruns1 == 1) idle1 <= idle1 + 1;
        end
    end

    task automatic run_frame(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d,
                             output bit timeout);
        @(posedge clock); #1;
        command8 = c; address16 = a; data32 = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total += 6;
        if (SSEL !== 1'b1) begin bad++; $display("FAIL reset_ssel: got %b want 1", SSEL); end
        if (SCK !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", SCK); end
        if (MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (read_data32 !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", read_data32);
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_frame_start();
        bit to;
        @(posedge clock); #1;
        command8 = 8'h81; address16 = 16'h0000; data32 = 32'h0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        total += 4;
        if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
        if (SSEL !== 1'b0) begin bad++; $display("FAIL start_ssel: got %b want 0", SSEL); end
        if (SCK !== 1'b0) begin bad++; $display("FAIL start_sck: got %b want 0", SCK); end
        if (MOSI !== 1'b1) begin bad++; $display("FAIL start_mosi: got %b want 1", MOSI); end
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (!busy) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL start_timeout: got busy want idle"); end
    endtask

    task automatic test_loopback(input string name, input logic [7:0] c, input logic [15:0] a,
                                 input logic [31:0] d, input logic [55:0] exp_stream);
        int s0, d0;
        bit to;
        miso_loop = 1'b1;
        s0 = sck_rises; d0 = done_cnt;
        run_frame(c, a, d, to);
        total += 8;
        if (to) begin bad++; $display("FAIL %s_timeout: got busy want idle", name); end
        if (stream !== exp_stream) begin
            bad++; $display("FAIL %s_stream: got %h want %h", name, stream, exp_stream);
        end
        if (sck_rises - s0 != 56) begin
            bad++; $display("FAIL %s_sck_edges: got %0d want 56", name, sck_rises - s0);
        end
        if (last_busy_run != 228) begin
            bad++; $display("FAIL %s_busy_len: got %0d want 228", name, last_busy_run);
        end
        if (last_ssel_run != 226) begin
            bad++; $display("FAIL %s_ssel_len: got %0d want 226", name, last_ssel_run);
        end
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt - d0);
        end
        if (read_data32 !== d) begin
            bad++; $display("FAIL %s_rdata: got %h want %h", name, read_data32, d);
        end
        if (MOSI !== 1'b0 || SSEL !== 1'b1) begin
            bad++; $display("FAIL %s_idle_lines: got mosi=%b ssel=%b want 0 1", name, MOSI, SSEL);
        end
    endtask

    task automatic test_miso_high();
        bit to;
        miso_loop = 1'b0; miso_val = 1'b1;
        run_frame(8'hA5, 16'h1234, 32'h0F0F_0F0F, to);
        total += 4;
        if (to) begin bad++; $display("FAIL miso1_timeout: got busy want idle"); end
        if (read_data32 !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL miso1_rdata: got %h want ffffffff", read_data32);
        end
        if (last_ssel_run != 226) begin
            bad++; $display("FAIL miso1_ssel_len: got %0d want 226", last_ssel_run);
        end
        if (stream !== 56'hA51234_0F0F0F0F) begin
            bad++; $display("FAIL miso1_stream: got %h want a512340f0f0f0f", stream);
        end
        miso_loop = 1'b1;
    endtask

    task automatic test_start_ignored();
        int d0;
        bit to;
        miso_loop = 1'b1;
        d0 = done_cnt;
        @(posedge clock); #1;
        command8 = 8'h01; address16 = 16'h0003; data32 = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        command8 = 8'hFF; address16 = 16'hFFFF; data32 = 32'h1234_5678; start = 1'b1;
        total++;
        if (read_data32 !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL ignore_rdata_mid: got %h want ffffffff", read_data32);
        end
        @(posedge clock); #1;
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (!busy) begin to = 1'b0; break; end
        end
        repeat (3) @(posedge clock);
        #1;
        total += 5;
        if (to) begin bad++; $display("FAIL ignore_timeout: got busy want idle"); end
        if (stream !== StreamDead) begin
            bad++; $display("FAIL ignore_stream: got %h want %h", stream, StreamDead);
        end
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL ignore_done_cnt: got %0d want 1", done_cnt - d0);
        end
        if (read_data32 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL ignore_rdata: got %h want deadbeef", read_data32);
        end
        if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue: got %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int s0, d0;
        bit to;
        miso_loop = 1'b1;
        s0 = sck_rises; d0 = done_cnt;
        @(posedge clock); #1;
        command8 = 8'h01; address16 = 16'h0003; data32 = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock); #1;
            if (sck_rises - s0 >= 20) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL abort_wait: got %0d edges want 20", sck_rises - s0); end
        #1 reset = 1'b1;
        #1;
        total += 4;
        if (SSEL !== 1'b1) begin bad++; $display("FAIL abort_ssel: got %b want 1", SSEL); end
        if (SCK !== 1'b0) begin bad++; $display("FAIL abort_sck: got %b want 0", SCK); end
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (read_data32 !== 32'h0) begin
            bad++; $display("FAIL abort_rdata: got %h want 0", read_data32);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (done_cnt != d0) begin
            bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0);
        end
        test_loopback("after_abort", 8'h02, 16'h0010, 32'hCAFE_F00D, StreamCafe);
    endtask

    task automatic test_back_to_back();
        bit to;
        @(posedge clock); #1;
        start1 = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        start1 = 1'b0;
        total += 5;
        if (runs1[0] != 114 || runs1[1] != 114) begin
            bad++; $display("FAIL b2b_busy_len: got %0d %0d want 114 114", runs1[0], runs1[1]);
        end
        if (idle1 != 1) begin bad++; $display("FAIL b2b_idle_gap: got %0d want 1", idle1); end
        if (done1_cnt != 2) begin bad++; $display("FAIL b2b_done: got %0d want 2", done1_cnt); end
        if (gap1 != 2) begin bad++; $display("FAIL b2b_ssel_gap: got %0d want 2", gap1); end
        if (rd1 !== 32'h1234_5678) begin
            bad++; $display("FAIL b2b_rdata: got %h want 12345678", rd1);
        end
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clock); #1;
            if (!busy1) begin to = 1'b0; break; end
        end
        repeat (2) @(posedge clock);
        #1;
        total += 2;
        if (to) begin bad++; $display("FAIL b2b_timeout: got busy want idle"); end
        if (done1_cnt != 3) begin
            bad++; $display("FAIL b2b_third: got %0d want 3", done1_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_loopback("dead", 8'h01, 16'h0003, 32'hDEAD_BEEF, StreamDead);
        test_loopback("ones", 8'hFF, 16'hFFFF, 32'h0000_0001, StreamOne);
        test_miso_high();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
